// File: rtl/sc_config_sequencer.sv
// Shadow/active configuration store for the output scan converter.
// CPU writes land in shadow words; they are copied to active words together at a frame boundary.
module sc_config_sequencer #(
  parameter int unsigned NUM_WORDS      = 9,
  parameter int unsigned TIMEOUT_CYCLES = 4194304,
  parameter int unsigned TO_W           = 23
) (
  input  logic        PCLK_OUT_i,
  input  logic        reset_i,
  input  logic        wr_en_i,
  input  logic [3:0]  wr_addr_i,
  input  logic [31:0] wr_data_i,
  input  logic [4:0]  rd_addr_i,
  output logic [31:0] rd_data_o,
  input  logic        commit_req_i,
  input  logic        force_commit_i,
  input  logic        VSYNC_i,
  output logic [31:0] hv_out_config_o,
  output logic [31:0] hv_out_config2_o,
  output logic [31:0] hv_out_config3_o,
  output logic [31:0] xy_out_config_o,
  output logic [31:0] xy_out_config2_o,
  output logic [31:0] misc_config_o,
  output logic [31:0] sl_config_o,
  output logic [31:0] sl_config2_o,
  output logic        testpattern_enable_o,
  output logic        pending_o,
  output logic        dirty_o,
  output logic        commit_done_o,
  output logic        timeout_o
);

  localparam int unsigned DW = 32;

  typedef logic [NUM_WORDS-1:0][DW-1:0] word_arr_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PENDING,
    ST_COMMIT
  } state_e;

  state_e            state_q, state_d;
  word_arr_t         shadow_q, shadow_d;
  word_arr_t         active_q, active_d;
  logic [DW-1:0]     rd_data_q, rd_data_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              pending_q, pending_d;
  logic              dirty_q, dirty_d;
  logic              commit_done_q, commit_done_d;
  logic              timeout_q, timeout_d;
  logic              vsync_q, vsync_d;
  logic              vsync_prev_q, vsync_prev_d;

  logic              wr_valid_c;
  logic              frame_edge_c;
  logic [3:0]        rd_idx_c;

  // Next-state, shadow/active update and readback selection.
  always_comb begin
    state_d       = state_q;
    shadow_d      = shadow_q;
    active_d      = active_q;
    rd_data_d     = '0;
    to_cnt_d      = to_cnt_q;
    pending_d     = pending_q;
    dirty_d       = dirty_q;
    commit_done_d = 1'b0;
    timeout_d     = timeout_q;
    vsync_d       = VSYNC_i;
    vsync_prev_d  = vsync_q;

    wr_valid_c   = wr_en_i && (32'(wr_addr_i) < NUM_WORDS);
    frame_edge_c = vsync_prev_q && !vsync_q;
    rd_idx_c     = rd_addr_i[3:0];

    if (wr_valid_c) begin
      shadow_d[wr_addr_i] = wr_data_i;
      dirty_d             = 1'b1;
    end

    if (32'(rd_idx_c) < NUM_WORDS) begin
      rd_data_d = rd_addr_i[4] ? active_q[rd_idx_c] : shadow_q[rd_idx_c];
    end

    case (state_q)
      ST_IDLE: begin
        if (force_commit_i) begin
          state_d = ST_COMMIT;
        end else if (commit_req_i) begin
          state_d   = ST_PENDING;
          pending_d = 1'b1;
          to_cnt_d  = '0;
          timeout_d = 1'b0;
        end
      end
      ST_PENDING: begin
        // A real frame edge takes priority so a coincident timeout is not flagged.
        if (frame_edge_c || force_commit_i) begin
          state_d = ST_COMMIT;
        end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          state_d   = ST_COMMIT;
          timeout_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      ST_COMMIT: begin
        // Copies the pre-write shadow; a write this cycle stays pending in shadow.
        active_d      = shadow_q;
        pending_d     = 1'b0;
        dirty_d       = wr_valid_c;
        commit_done_d = 1'b1;
        state_d       = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK_OUT_i) begin
    if (reset_i) begin
      state_q       <= ST_IDLE;
      shadow_q      <= '0;
      active_q      <= '0;
      rd_data_q     <= '0;
      to_cnt_q      <= '0;
      pending_q     <= 1'b0;
      dirty_q       <= 1'b0;
      commit_done_q <= 1'b0;
      timeout_q     <= 1'b0;
      vsync_q       <= 1'b1;
      vsync_prev_q  <= 1'b1;
    end else begin
      state_q       <= state_d;
      shadow_q      <= shadow_d;
      active_q      <= active_d;
      rd_data_q     <= rd_data_d;
      to_cnt_q      <= to_cnt_d;
      pending_q     <= pending_d;
      dirty_q       <= dirty_d;
      commit_done_q <= commit_done_d;
      timeout_q     <= timeout_d;
      vsync_q       <= vsync_d;
      vsync_prev_q  <= vsync_prev_d;
    end
  end

  assign rd_data_o            = rd_data_q;
  assign hv_out_config_o      = active_q[0];
  assign hv_out_config2_o     = active_q[1];
  assign hv_out_config3_o     = active_q[2];
  assign xy_out_config_o      = active_q[3];
  assign xy_out_config2_o     = active_q[4];
  assign misc_config_o        = active_q[5];
  assign sl_config_o          = active_q[6];
  assign sl_config2_o         = active_q[7];
  assign testpattern_enable_o = active_q[8][0];
  assign pending_o            = pending_q;
  assign dirty_o              = dirty_q;
  assign commit_done_o        = commit_done_q;
  assign timeout_o            = timeout_q;

endmodule

// File: tb/tb_sc_config_sequencer.sv
// Scoreboard bench for sc_config_sequencer: reads and commits are predicted from a shadow/active model.
module tb_sc_config_sequencer;

  typedef logic [8:0][31:0] words_t;
  typedef struct packed {
    words_t     words;
    logic       to;
    logic [7:0] lat;
  } commit_t;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        wr_en_i = 1'b0;
  logic [3:0]  wr_addr_i = '0;
  logic [31:0] wr_data_i = '0;
  logic [4:0]  rd_addr_i = '0;
  logic [31:0] rd_data_o;
  logic        commit_req_i = 1'b0;
  logic        force_commit_i = 1'b0;
  logic        VSYNC_i = 1'b1;
  logic [31:0] hv_out_config_o, hv_out_config2_o, hv_out_config3_o, xy_out_config_o;
  logic [31:0] xy_out_config2_o, misc_config_o, sl_config_o, sl_config2_o;
  logic        testpattern_enable_o, pending_o, dirty_o, commit_done_o, timeout_o;

  int checks = 0;
  int failures = 0;

  logic [31:0] sh_m [9];
  logic [31:0] ac_m [9];
  logic [31:0] rd_q [$];
  commit_t     cm_q [$];

  sc_config_sequencer #(
    .NUM_WORDS(9),
    .TIMEOUT_CYCLES(16),
    .TO_W(5)
  ) dut (
    .PCLK_OUT_i(clk),
    .reset_i(reset_i),
    .wr_en_i(wr_en_i),
    .wr_addr_i(wr_addr_i),
    .wr_data_i(wr_data_i),
    .rd_addr_i(rd_addr_i),
    .rd_data_o(rd_data_o),
    .commit_req_i(commit_req_i),
    .force_commit_i(force_commit_i),
    .VSYNC_i(VSYNC_i),
    .hv_out_config_o(hv_out_config_o),
    .hv_out_config2_o(hv_out_config2_o),
    .hv_out_config3_o(hv_out_config3_o),
    .xy_out_config_o(xy_out_config_o),
    .xy_out_config2_o(xy_out_config2_o),
    .misc_config_o(misc_config_o),
    .sl_config_o(sl_config_o),
    .sl_config2_o(sl_config2_o),
    .testpattern_enable_o(testpattern_enable_o),
    .pending_o(pending_o),
    .dirty_o(dirty_o),
    .commit_done_o(commit_done_o),
    .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic words_t snap_shadow();
    words_t w;
    for (int i = 0; i < 9; i++) w[i] = sh_m[i];
    w[8] = {31'b0, sh_m[8][0]};
    return w;
  endfunction

  function automatic words_t dut_active();
    words_t w;
    w[0] = hv_out_config_o;  w[1] = hv_out_config2_o; w[2] = hv_out_config3_o;
    w[3] = xy_out_config_o;  w[4] = xy_out_config2_o; w[5] = misc_config_o;
    w[6] = sl_config_o;      w[7] = sl_config2_o;
    w[8] = {31'b0, testpattern_enable_o};
    return w;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a[3:0] > 4'd8) return 32'h0;
    return a[4] ? ac_m[a[3:0]] : sh_m[a[3:0]];
  endfunction

  task automatic drive_write(input logic [3:0] a, input logic [31:0] d);
    wr_en_i = 1'b1; wr_addr_i = a; wr_data_i = d;
    if (a <= 4'd8) sh_m[a] = d;
    tick();
    wr_en_i = 1'b0;
  endtask

  task automatic model_commit(input words_t w);
    for (int i = 0; i < 9; i++) ac_m[i] = sh_m[i];
    if (w !== snap_shadow()) ac_m[1] = w[1];
  endtask

  task automatic test_reset();
    logic [31:0] got;
    logic [4:0]  a;
    reset_i = 1'b1; VSYNC_i = 1'b1;
    for (int i = 0; i < 9; i++) begin sh_m[i] = '0; ac_m[i] = '0; end
    tick(); tick();
    reset_i = 1'b0;
    checks++;
    if ({pending_o, dirty_o, commit_done_o, timeout_o} !== 4'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b want=0000", {pending_o, dirty_o, commit_done_o, timeout_o});
    end
    checks++;
    if (dut_active() !== '0) begin
      failures++;
      $display("FAIL reset_active got=%h want=0", dut_active());
    end
    for (int i = 0; i < 20; i++) begin
      a = (i < 9) ? 5'(i) : (i < 18) ? 5'(16 + i - 9) : (i == 18 ? 5'd9 : 5'd31);
      rd_addr_i = a;
      rd_q.push_back(exp_rd(a));
      tick();
      got = rd_q.pop_front();
      checks++;
      if (rd_data_o !== got) begin
        failures++;
        $display("FAIL reset_read idx=%0d got=%h want=%h", a, rd_data_o, got);
      end
    end
  endtask

  task automatic test_write();
    logic [31:0] got;
    logic [4:0]  addrs [5];
    drive_write(4'd0, 32'h1234_5678);
    drive_write(4'd8, 32'h0000_0001);
    drive_write(4'd12, 32'hDEAD_BEEF);
    addrs[0] = 5'd0; addrs[1] = 5'd16; addrs[2] = 5'd8; addrs[3] = 5'd24; addrs[4] = 5'd12;
    for (int i = 0; i < 5; i++) begin
      rd_addr_i = addrs[i];
      rd_q.push_back(exp_rd(addrs[i]));
      tick();
      got = rd_q.pop_front();
      checks++;
      if (rd_data_o !== got) begin
        failures++;
        $display("FAIL write_read idx=%0d got=%h want=%h", addrs[i], rd_data_o, got);
      end
    end
    checks++;
    if (dirty_o !== 1'b1 || hv_out_config_o !== 32'h0) begin
      failures++;
      $display("FAIL write_flags dirty=%b hv=%h want dirty=1 hv=0", dirty_o, hv_out_config_o);
    end
  endtask

  task automatic test_frame_commit();
    commit_t e;
    int cyc;
    commit_req_i = 1'b1;
    tick();
    commit_req_i = 1'b0;
    checks++;
    if (pending_o !== 1'b1) begin
      failures++;
      $display("FAIL frame_pending got=%b want=1", pending_o);
    end
    tick(); tick();
    VSYNC_i = 1'b0;
    cm_q.push_back('{words: snap_shadow(), to: 1'b0, lat: 8'd3});
    for (cyc = 1; cyc <= 40; cyc++) begin
      tick();
      if (commit_done_o === 1'b1) break;
    end
    e = cm_q.pop_front();
    checks++;
    if (cyc !== int'(e.lat)) begin
      failures++;
      $display("FAIL frame_latency got=%0d want=%0d", cyc, e.lat);
    end
    checks++;
    if (dut_active() !== e.words) begin
      failures++;
      $display("FAIL frame_active got=%h want=%h", dut_active(), e.words);
    end
    model_commit(e.words);
    checks++;
    if ({pending_o, dirty_o, timeout_o} !== {2'b00, e.to}) begin
      failures++;
      $display("FAIL frame_flags got=%b want=00%b", {pending_o, dirty_o, timeout_o}, e.to);
    end
    tick();
    VSYNC_i = 1'b1;
    checks++;
    if (commit_done_o !== 1'b0) begin
      failures++;
      $display("FAIL frame_done_pulse got=%b want=0", commit_done_o);
    end
    tick(); tick();
  endtask

  task automatic test_timeout();
    commit_t e;
    int cyc;
    drive_write(4'd2, 32'hCAFE_0002);
    commit_req_i = 1'b1;
    cm_q.push_back('{words: snap_shadow(), to: 1'b1, lat: 8'd18});
    for (cyc = 1; cyc <= 60; cyc++) begin
      tick();
      commit_req_i = 1'b0;
      if (commit_done_o === 1'b1) break;
    end
    e = cm_q.pop_front();
    checks++;
    if (cyc !== int'(e.lat)) begin
      failures++;
      $display("FAIL timeout_latency got=%0d want=%0d", cyc, e.lat);
    end
    checks++;
    if (dut_active() !== e.words || timeout_o !== e.to) begin
      failures++;
      $display("FAIL timeout_commit active=%h to=%b want=%h to=%b", dut_active(), timeout_o, e.words, e.to);
    end
    model_commit(e.words);
    tick();
    commit_req_i = 1'b1;
    tick();
    commit_req_i = 1'b0;
    checks++;
    if (timeout_o !== 1'b0 || pending_o !== 1'b1) begin
      failures++;
      $display("FAIL timeout_clear to=%b pending=%b want to=0 pending=1", timeout_o, pending_o);
    end
  endtask

  task automatic test_commit_cycle_write();
    commit_t e;
    logic [31:0] got;
    logic [4:0]  addrs [2];
    VSYNC_i = 1'b0;
    cm_q.push_back('{words: snap_shadow(), to: 1'b0, lat: 8'd3});
    tick();
    tick();
    wr_en_i = 1'b1; wr_addr_i = 4'd1; wr_data_i = 32'h0000_000A;
    sh_m[1] = 32'h0000_000A;
    tick();
    wr_en_i = 1'b0;
    VSYNC_i = 1'b1;
    e = cm_q.pop_front();
    checks++;
    if (commit_done_o !== 1'b1 || dut_active() !== e.words) begin
      failures++;
      $display("FAIL ccw_commit done=%b active=%h want done=1 active=%h", commit_done_o, dut_active(), e.words);
    end
    for (int i = 0; i < 9; i++) ac_m[i] = e.words[i];
    ac_m[8] = sh_m[8];
    checks++;
    if (dirty_o !== 1'b1 || timeout_o !== 1'b0 || pending_o !== 1'b0) begin
      failures++;
      $display("FAIL ccw_flags dirty=%b to=%b pending=%b want 1 0 0", dirty_o, timeout_o, pending_o);
    end
    addrs[0] = 5'd1; addrs[1] = 5'd17;
    for (int i = 0; i < 2; i++) begin
      rd_addr_i = addrs[i];
      rd_q.push_back(exp_rd(addrs[i]));
      tick();
      got = rd_q.pop_front();
      checks++;
      if (rd_data_o !== got) begin
        failures++;
        $display("FAIL ccw_read idx=%0d got=%h want=%h", addrs[i], rd_data_o, got);
      end
    end
  endtask

  task automatic test_force();
    commit_t e;
    int cyc;
    logic pend_seen = 1'b0;
    logic done_seen = 1'b0;
    force_commit_i = 1'b1;
    commit_req_i = 1'b1;
    cm_q.push_back('{words: snap_shadow(), to: 1'b0, lat: 8'd2});
    for (cyc = 1; cyc <= 20; cyc++) begin
      tick();
      force_commit_i = 1'b0;
      commit_req_i = 1'b0;
      pend_seen |= pending_o;
      if (commit_done_o === 1'b1) break;
    end
    e = cm_q.pop_front();
    checks++;
    if (cyc !== int'(e.lat) || dut_active() !== e.words) begin
      failures++;
      $display("FAIL force_commit lat=%0d active=%h want lat=%0d active=%h", cyc, dut_active(), e.lat, e.words);
    end
    model_commit(e.words);
    checks++;
    if (hv_out_config2_o !== 32'h0000_000A || dirty_o !== 1'b0) begin
      failures++;
      $display("FAIL force_word1 hv2=%h dirty=%b want hv2=0000000a dirty=0", hv_out_config2_o, dirty_o);
    end
    tick();
    VSYNC_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      pend_seen |= pending_o;
      done_seen |= commit_done_o;
    end
    VSYNC_i = 1'b1;
    checks++;
    if (pend_seen !== 1'b0 || done_seen !== 1'b0) begin
      failures++;
      $display("FAIL force_no_pending pending_seen=%b done_seen=%b want 0 0", pend_seen, done_seen);
    end
  endtask

  task automatic test_reset_mid_pending();
    drive_write(4'd3, 32'h0BAD_F00D);
    commit_req_i = 1'b1;
    tick();
    commit_req_i = 1'b0;
    tick();
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    for (int i = 0; i < 9; i++) begin sh_m[i] = '0; ac_m[i] = '0; end
    checks++;
    if (dut_active() !== '0 || pending_o !== 1'b0 || dirty_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_pending active=%h pending=%b dirty=%b want 0", dut_active(), pending_o, dirty_o);
    end
    VSYNC_i = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    VSYNC_i = 1'b1;
    checks++;
    if (xy_out_config_o !== 32'h0) begin
      failures++;
      $display("FAIL reset_pending_edge xy=%h want 0", xy_out_config_o);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_frame_commit();
    test_timeout();
    test_commit_cycle_write();
    test_force();
    test_reset_mid_pending();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sc_config_sequencer.md
Name: sc_config_sequencer

Overview:
- Owns every run-time configuration word of the output scan converter (timing, scaling/offset, misc, scanline).
- Holds them as CPU-writable shadow registers and commits them atomically to active registers at the next output frame boundary.
- The scan converter therefore never sees a partially updated mode mid-frame.
- Sits between the CPU register bus and the scan converter config inputs, in the output pixel clock domain.

Parameters:
- NUM_WORDS, 9, config words held (index 0..8 as listed under Ports).
- TIMEOUT_CYCLES, 4194304, output clocks without a frame boundary before a pending commit is forced.
- TO_W, 23, width of timeout counter (must hold TIMEOUT_CYCLES).

Ports:
- PCLK_OUT_i  in  1  output pixel clock; only clock.
- reset_i  in  1  synchronous, active-high reset.
- wr_en_i  in  1  shadow write strobe.
- wr_addr_i  in  4  shadow word index; values >= NUM_WORDS ignored.
- wr_data_i  in  32  shadow write data.
- rd_addr_i  in  5  readback index: bit4=0 shadow, bit4=1 active; low 4 bits word index.
- rd_data_o  out  32  readback data, registered.
- commit_req_i  in  1  single-cycle request to commit shadow at next frame boundary.
- force_commit_i  in  1  commit immediately, regardless of frame position.
- VSYNC_i  in  1  active-low output VSYNC from the scan converter.
- hv_out_config_o, hv_out_config2_o, hv_out_config3_o, xy_out_config_o, xy_out_config2_o, misc_config_o, sl_config_o, sl_config2_o  out  32 each  active words 0..7.
- testpattern_enable_o  out  1  active word 8 bit0.
- pending_o  out  1  commit armed, not yet applied.
- dirty_o  out  1  shadow differs from active since last commit.
- commit_done_o  out  1  one-cycle pulse in the cycle after active registers update.
- timeout_o  out  1  sticky: last commit was forced by timeout; cleared by next commit_req_i.

Behaviour:
- Reset:
  - all shadow and active words = 0; rd_data_o = 0.
  - pending_o, dirty_o, commit_done_o, timeout_o = 0; state IDLE; timeout counter = 0.
- Frame boundary: falling edge of VSYNC_i (previous sample 1, current sample 0). VSYNC_i is sampled through one register; the edge is detected on the registered value.
- Writes:
  - shadow[wr_addr_i] <= wr_data_i on the clock after wr_en_i; any state.
  - dirty_o set on any valid write; cleared on commit unless a write occurs in the commit cycle.
- Readback: rd_data_o <= selected word one cycle after rd_addr_i; invalid index returns 0.
- State machine:
  - IDLE:
    - commit_req_i -> PENDING; pending_o=1; timeout counter cleared; timeout_o cleared.
    - force_commit_i -> COMMIT.
  - PENDING:
    - frame-boundary edge -> COMMIT.
    - force_commit_i -> COMMIT.
    - counter reaching TIMEOUT_CYCLES-1 -> COMMIT, with timeout_o<=1.
    - commit_req_i ignored (already armed).
    - otherwise counter increments.
  - COMMIT (one cycle):
    - active[all] <= shadow[all] as held at the start of this cycle.
    - A write in this same cycle lands in shadow only and leaves dirty_o=1.
    - pending_o<=0; next state IDLE; commit_done_o pulses the following cycle.
- Latency:
  - VSYNC_i falling at pin, cycle N: edge seen at N+1, COMMIT state at N+2, active outputs change at end of N+2, commit_done_o high in N+3.
  - Forced commit: outputs change 2 cycles after force_commit_i.
- Simultaneous events:
  - force_commit_i with commit_req_i: force wins; no PENDING afterwards.
  - Edge and timeout in the same cycle: treated as an edge; timeout_o stays 0.
- Reset mid-PENDING: pending lost; active words return to 0.

Test Plan:
- Reset, then read all 18 indices -> every rd_data_o = 0; pending_o/dirty_o/commit_done_o = 0.
- Write word0=0x12345678, word8=1; read shadow idx0 -> 0x12345678; active idx0 = 0; dirty_o=1; hv_out_config_o=0.
- commit_req_i, then VSYNC_i 1->0 at cycle N -> hv_out_config_o=0x12345678 and testpattern_enable_o=1 from N+3; commit_done_o high exactly at N+3; pending_o=0; dirty_o=0.
- commit_req_i with VSYNC_i held 1, TIMEOUT_CYCLES=16 -> commit after 16 cycles in PENDING; timeout_o=1; next commit_req_i clears it.
- Write word1=0xA in the COMMIT cycle -> hv_out_config2_o keeps its old value; shadow idx1=0xA; dirty_o=1.
- force_commit_i with commit_req_i in the same cycle -> active updates 2 cycles later; pending_o never asserted; a later VSYNC edge causes no commit_done_o.
